// File: rtl/m1t_mem_pkg.sv
// Shared types for the M1T memory-port arbiter: request modes, arbiter
// states and the requester-id width used by the read-tag FIFO.
package m1t_mem_pkg;

    typedef enum logic [1:0] {
        READ    = 2'd0,
        WRITE   = 2'd1,
        FENCE_A = 2'd2,
        FENCE_B = 2'd3
    } mem_mode_t;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        DRAIN = 2'd1,
        FENCE = 2'd2
    } arb_state_t;

    localparam int REQ_ID_W = 1;

    // Both fence encodings have the upper mode bit set.
    function automatic logic is_fence(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/m1t_tag_fifo.sv
// Small FIFO holding the requester id of every outstanding read, in issue
// order, so responses can be routed back to the requester that issued them.
// A push while full is accepted only when a pop happens in the same cycle.
module m1t_tag_fifo
    import m1t_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  logic [REQ_ID_W-1:0] i_push_id,
    input  logic                i_pop,
    output logic                o_full,
    output logic                o_empty,
    output logic [REQ_ID_W-1:0] o_head_id
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [REQ_ID_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head_id = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Tag storage write port.
    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and the empty/full flags come from reset counters.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter_m1t.sv
// Round-robin arbiter sharing the single M1T memory-controller port between
// two requesters. Reads are tagged with their owner so responses route back,
// and fences are held until every outstanding read has drained.
module mem_port_arbiter_m1t
    import m1t_mem_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   async_rst_n,
    input  logic                   clk_en,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][1:0]        req_mask,
    input  logic [1:0][1:0]        req_type,
    input  logic [1:0][DATA_W-1:0] req_data,
    input  logic [1:0][1:0]        req_mode,
    input  logic [1:0][3:0]        req_wb_dest,
    output logic [1:0]             resp_valid,
    output logic [DATA_W-1:0]      resp_data,
    output logic [3:0]             resp_wb_dest,
    output logic [ADDR_W-1:0]      mem_address_out,
    output logic [1:0]             mem_mask_out,
    output logic [1:0]             mem_read_fnc_type,
    output logic [DATA_W-1:0]      mem_data_out,
    output logic [1:0]             mem_mode,
    output logic [3:0]             mem_wb_dest,
    output logic                   mem_enable,
    output logic                   mem_input_ready,
    input  logic [DATA_W-1:0]      mem_data_in,
    input  logic [3:0]             mem_wb_dest_in,
    input  logic                   mem_read_ack,
    input  logic                   mem_available,
    input  logic                   mem_idle,
    output logic                   tag_err
);

    arb_state_t r_state;
    logic       r_last_grant;
    logic       r_fence_owner;
    logic [1:0] r_fence_mode;
    logic       r_tag_err;

    logic       w_rr_win;
    logic [1:0] w_elig;
    logic       w_has_win;
    logic       w_win;
    logic       w_win_fence;
    logic       w_win_read;
    logic       w_full;
    logic       w_empty;
    logic       w_head;
    logic       w_pop;
    logic       w_push;
    logic       w_arb_fire;
    logic       w_fence_fire;
    logic       w_present;
    logic       w_sel;

    m1t_tag_fifo #(
        .DEPTH(TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (async_rst_n),
        .i_push   (w_push),
        .i_push_id(w_win),
        .i_pop    (w_pop),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_head_id(w_head)
    );

    // Winner selection, fire qualification and output muxing. A fence is only
    // eligible when it would win round-robin anyway, so it never overtakes.
    // NOTE: every signal gets a default at the top so no latch is inferred.
    always_comb begin
        w_rr_win     = (&req_valid) ? ~r_last_grant : req_valid[1];
        w_elig[0]    = req_valid[0] && (!is_fence(req_mode[0]) || !w_rr_win);
        w_elig[1]    = req_valid[1] && (!is_fence(req_mode[1]) ||  w_rr_win);
        w_has_win    = |w_elig;
        w_win        = (&w_elig) ? ~r_last_grant : w_elig[1];
        w_win_fence  = is_fence(req_mode[w_win]);
        w_win_read   = (req_mode[w_win] == READ);

        w_pop        = async_rst_n && clk_en && mem_read_ack && !w_empty;
        w_arb_fire   = async_rst_n && clk_en && mem_available && (r_state == ARB)
                       && w_has_win && !w_win_fence && !(w_win_read && w_full && !w_pop);
        w_fence_fire = async_rst_n && clk_en && mem_available && (r_state == FENCE);
        w_push       = w_arb_fire && w_win_read;

        w_sel        = (r_state == FENCE) ? r_fence_owner : w_win;
        w_present    = async_rst_n && (((r_state == ARB) && w_has_win && !w_win_fence)
                                       || (r_state == FENCE));

        req_ready         = (w_arb_fire || w_fence_fire) ? (2'b01 << w_sel) : 2'b00;
        mem_input_ready   = w_arb_fire || w_fence_fire;
        mem_enable        = w_present;
        mem_address_out   = w_present ? req_addr[w_sel]    : '0;
        mem_mask_out      = w_present ? req_mask[w_sel]    : '0;
        mem_read_fnc_type = w_present ? req_type[w_sel]    : '0;
        mem_data_out      = w_present ? req_data[w_sel]    : '0;
        mem_wb_dest       = w_present ? req_wb_dest[w_sel] : '0;
        mem_mode          = '0;
        if (w_present) begin
            mem_mode = (r_state == FENCE) ? r_fence_mode : req_mode[w_sel];
        end

        resp_valid   = w_pop ? (2'b01 << w_head) : 2'b00;
        resp_data    = async_rst_n ? mem_data_in    : '0;
        resp_wb_dest = async_rst_n ? mem_wb_dest_in : '0;
        tag_err      = r_tag_err;
    end

    // Arbiter state machine: round-robin history, fence capture and drain.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_state       <= ARB;
            r_last_grant  <= 1'b1;
            r_fence_owner <= 1'b0;
            r_fence_mode  <= FENCE_A;
            r_tag_err     <= 1'b0;
        end else if (clk_en) begin
            if (mem_read_ack && w_empty) begin
                r_tag_err <= 1'b1;
            end
            case (r_state)
                ARB: begin
                    if (w_arb_fire) begin
                        r_last_grant <= w_win;
                    end else if (w_has_win && w_win_fence) begin
                        r_fence_owner <= w_win;
                        r_fence_mode  <= req_mode[w_win];
                        r_state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_empty && mem_idle) r_state <= FENCE;
                end
                FENCE: begin
                    if (mem_available) begin
                        r_last_grant <= r_fence_owner;
                        r_state      <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

endmodule
